// File: rtl/bm_pkg.sv
// Shared block-map geometry, controller state type and the block-fill LFSR step.
package bm_pkg;

    localparam int MAP_COLS  = 17;
    localparam int MAP_ROWS  = 13;
    localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
    localparam int ADDR_W    = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/map_write_ctrl_if.sv
// Explosion-clear request handshake plus the block-map RAM write port.
interface map_write_ctrl_if;
    import bm_pkg::*;

    logic              exp_valid;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              wdata;

    // Requester side: issues clear requests and observes the RAM writes.
    modport master (
        output exp_valid, exp_addr,
        input  exp_ready, we, waddr, wdata
    );

    // Controller side: accepts requests and owns the RAM write port.
    modport slave (
        input  exp_valid, exp_addr,
        output exp_ready, we, waddr, wdata
    );

endinterface

// File: rtl/map_write_ctrl_req_fifo.sv
// Small synchronous request queue holding pending explosion-clear addresses.
module req_fifo
    import bm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ADDR_W
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping; a flush empties the queue without touching storage.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; an entry is only read after it has been written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/map_write_ctrl.sv
// Sole owner of the block-map RAM write port: full-map initialisation sweeps
// with LFSR-filled blocks, and queued explosion clears, both gated to blanking.
module map_write_ctrl
    import bm_pkg::*;
#(
    parameter int          MAP_COLS   = bm_pkg::MAP_COLS,
    parameter int          MAP_ROWS   = bm_pkg::MAP_ROWS,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter bit          GATE_BLANK = 1'b1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             display_on,
    input  logic             init_start,
    map_write_ctrl_if.slave  bus,
    output logic             init_done,
    output logic             busy
);

    localparam int DEPTH = MAP_COLS * MAP_ROWS;
    localparam int ROW_W = $clog2(MAP_ROWS);
    localparam int COL_W = $clog2(MAP_COLS);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ROW_W-1:0]  r_row;
    logic [ROW_W-1:0]  w_row_nxt;
    logic [COL_W-1:0]  r_col;
    logic [COL_W-1:0]  w_col_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [15:0]       r_lfsr;

    logic              r_we;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic              r_wdata;
    logic              w_wdata_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic              r_init_done;

    logic              w_eligible;
    logic              w_block;
    logic              w_exp_ready;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic              w_fifo_flush;
    logic [ADDR_W-1:0] w_fifo_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;

    // A write may only be launched while the display is blanked (unless gating is disabled).
    assign w_eligible = !GATE_BLANK || !display_on;

    // Block present unless the LFSR says empty, the cell is a pillar, or it is a spawn cell.
    assign w_block = (r_lfsr[1:0] != 2'b00)
                  && !(r_row[0] && r_col[0])
                  && !((r_addr == ADDR_W'(0)) || (r_addr == ADDR_W'(1))
                       || (r_addr == ADDR_W'(MAP_COLS)));

    assign w_fifo_push   = bus.exp_valid && w_exp_ready;
    assign bus.exp_ready = w_exp_ready;
    assign bus.we        = r_we;
    assign bus.waddr     = r_waddr;
    assign bus.wdata     = r_wdata;
    assign init_done     = r_init_done;
    assign busy          = (r_state == ST_INIT) || (w_fifo_count != '0);

    req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_fifo_flush),
        .i_push  (w_fifo_push),
        .i_din   (bus.exp_addr),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Next-state, sweep counters and the single write-port decision for this cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_addr_nxt   = r_addr;
        w_we_nxt     = 1'b0;
        w_waddr_nxt  = r_waddr;
        w_wdata_nxt  = r_wdata;
        w_last_nxt   = 1'b0;
        w_fifo_pop   = 1'b0;
        w_fifo_flush = 1'b0;
        w_exp_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_exp_ready = !init_start && !w_fifo_full;
                if (init_start) begin
                    // Pending clears are discarded: the sweep rewrites every cell anyway.
                    w_state_nxt  = ST_INIT;
                    w_row_nxt    = '0;
                    w_col_nxt    = '0;
                    w_addr_nxt   = '0;
                    w_fifo_flush = 1'b1;
                end else if (!w_fifo_empty && w_eligible) begin
                    w_fifo_pop = 1'b1;
                    // Out-of-range addresses are consumed without touching the RAM.
                    if (w_fifo_head < ADDR_W'(DEPTH)) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = w_fifo_head;
                        w_wdata_nxt = 1'b0;
                    end
                end
            end
            ST_INIT: begin
                if (w_eligible) begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = r_addr;
                    w_wdata_nxt = w_block;
                    if (r_addr == ADDR_W'(DEPTH - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = 1'b1;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_W'(1);
                        if (r_col == COL_W'(MAP_COLS - 1)) begin
                            w_col_nxt = '0;
                            w_row_nxt = r_row + ROW_W'(1);
                        end else begin
                            w_col_nxt = r_col + COL_W'(1);
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counters, free-running LFSR and registered write-port / done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_addr      <= '0;
            r_lfsr      <= LFSR_SEED;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= 1'b0;
            r_last      <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_addr      <= w_addr_nxt;
            r_lfsr      <= lfsr_next(r_lfsr);
            r_we        <= w_we_nxt;
            r_waddr     <= w_waddr_nxt;
            r_wdata     <= w_wdata_nxt;
            // Done trails the final write by one cycle so it follows the last RAM update.
            r_last      <= w_last_nxt;
            r_init_done <= r_last;
        end
    end

endmodule

// File: tb/tb_map_write_ctrl.sv
// Randomised self-checking bench for map_write_ctrl against a behavioural map/queue model.
`timescale 1ns/1ps
module tb_map_write_ctrl;

    localparam int          COLS  = 17;
    localparam int          CELLS = 221;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk = 1'b0;
    logic reset;
    logic display_on;
    logic init_start;
    logic init_done;
    logic busy;

    map_write_ctrl_if bus ();

    map_write_ctrl #(
        .MAP_COLS   (17),
        .MAP_ROWS   (13),
        .FIFO_DEPTH (4),
        .LFSR_SEED  (SEED),
        .GATE_BLANK (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .display_on (display_on),
        .init_start (init_start),
        .bus        (bus),
        .init_done  (init_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        bit          data;
        logic [15:0] lf;
        bit          elig;
        int          cyc;
    } wr_t;

    wr_t         wr_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    bit          m_elig;

    int mq[$];
    int expw[$];
    int qa[5];
    int n;
    int h;
    int a;
    bit v;
    bit d;
    bit exp_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic [15:0] b;
        b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
        return (s >> 1) | (b << 15);
    endfunction

    function automatic bit exp_block(input int addr, input logic [15:0] lf);
        int row;
        int col;
        bit pillar;
        bit spawn;
        row    = addr / COLS;
        col    = addr % COLS;
        pillar = (row % 2 == 1) && (col % 2 == 1);
        spawn  = (addr == 0) || (addr == 1) || (addr == COLS);
        return !pillar && !spawn && (lf[1:0] != 2'b00);
    endfunction

    // Model LFSR/eligibility at each edge, then record the DUT's registered writes.
    always @(posedge clk) begin
        m_prev = m_lfsr;
        m_lfsr = reset ? SEED : ref_lfsr(m_lfsr);
        m_elig = !display_on;
        cyc++;
        #1;
        if (bus.we === 1'b1)
            wr_q.push_back('{addr: int'(bus.waddr), data: bus.wdata, lf: m_prev, elig: m_elig, cyc: cyc});
        if (init_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic wait_done(input string tag, input int max_cyc);
        int k;
        k = 0;
        while (done_cnt == 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_sweep(input string tag);
        chk({tag, "_nwr"}, wr_q.size(), CELLS);
        for (int i = 0; i < wr_q.size() && i < CELLS; i++) begin
            chk({tag, "_addr"}, wr_q[i].addr, i);
            chk({tag, "_data"}, wr_q[i].data, exp_block(i, wr_q[i].lf));
            chk({tag, "_elig"}, wr_q[i].elig, 1);
        end
        if (wr_q.size() > 18) begin
            chk({tag, "_spawn0"}, wr_q[0].data, 0);
            chk({tag, "_spawn1"}, wr_q[1].data, 0);
            chk({tag, "_spawn17"}, wr_q[17].data, 0);
            chk({tag, "_pillar18"}, wr_q[18].data, 0);
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        if (wr_q.size() > 0)
            chk({tag, "_done_cyc"}, done_cyc, wr_q[wr_q.size()-1].cyc + 1);
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        display_on    = 1'b1;
        init_start    = 1'b0;
        bus.exp_valid = 1'b0;
        bus.exp_addr  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_we", bus.we, 0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_done", init_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.exp_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Full sweep with every cycle eligible
        wr_q.delete(); done_cnt = 0;
        display_on = 1'b0;
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        chk("sw_busy", busy, 1);
        chk("sw_ready", bus.exp_ready, 0);
        wait_done("sw", 1000);
        check_sweep("sw");

        // Gated sweep: held off by active video, then random blanking and a stray init_start
        wr_q.delete(); done_cnt = 0;
        display_on = 1'b1;
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        repeat (100) @(negedge clk);
        chk("gate_nowr", wr_q.size(), 0);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            display_on = 1'($urandom_range(0, 1));
            init_start = (n == 150);
            @(negedge clk);
            n++;
        end
        init_start = 1'b0;
        display_on = 1'b0;
        chk("gate_done_seen", done_cnt != 0, 1);
        repeat (4) @(negedge clk);
        check_sweep("gate");

        // Queue fill: four accepted, fifth refused while blanking is withheld
        wr_q.delete();
        display_on = 1'b1;
        qa = '{30, 31, 32, 47, 55};
        for (int i = 0; i < 5; i++) begin
            bus.exp_valid = 1'b1;
            bus.exp_addr  = 9'(qa[i]);
            #1;
            chk("q_ready", bus.exp_ready, (i < 4) ? 1 : 0);
            @(negedge clk);
        end
        bus.exp_valid = 1'b0;
        chk("q_busy", busy, 1);
        chk("q_held", wr_q.size(), 0);
        display_on = 1'b0;
        repeat (8) @(negedge clk);
        chk("q_nwr", wr_q.size(), 4);
        for (int i = 0; i < wr_q.size() && i < 4; i++) begin
            chk("q_addr", wr_q[i].addr, qa[i]);
            chk("q_data", wr_q[i].data, 0);
        end
        chk("q_busy_end", busy, 0);

        // Minimum latency into an empty queue
        wr_q.delete();
        bus.exp_valid = 1'b1;
        bus.exp_addr  = 9'd123;
        @(negedge clk);
        bus.exp_valid = 1'b0;
        chk("lat_k_we", bus.we, 0);
        @(negedge clk);
        chk("lat_k1_we", bus.we, 1);
        chk("lat_k1_addr", bus.waddr, 123);
        chk("lat_k1_data", bus.wdata, 0);
        repeat (2) @(negedge clk);

        // Out-of-range address is consumed silently
        wr_q.delete();
        bus.exp_valid = 1'b1;
        bus.exp_addr  = 9'd300;
        @(negedge clk);
        bus.exp_valid = 1'b0;
        chk("drop_busy_pend", busy, 1);
        repeat (3) @(negedge clk);
        chk("drop_nwr", wr_q.size(), 0);
        chk("drop_busy", busy, 0);

        // Random request traffic against a queue model
        wr_q.delete(); mq.delete(); expw.delete();
        for (int c = 0; c < 400; c++) begin
            v = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(221, 511)) : int'($urandom_range(0, 220));
            d = ($urandom_range(0, 2) == 0);
            bus.exp_valid = v;
            bus.exp_addr  = 9'(a);
            display_on    = d;
            #1;
            exp_rdy = (mq.size() < 4);
            chk("rq_ready", bus.exp_ready, exp_rdy);
            if (mq.size() > 0 && !d) begin
                h = mq.pop_front();
                if (h < CELLS) expw.push_back(h);
            end
            if (v && exp_rdy) mq.push_back(a);
            @(negedge clk);
        end
        bus.exp_valid = 1'b0;
        display_on    = 1'b0;
        repeat (8) @(negedge clk);
        chk("rq_nwr", wr_q.size(), expw.size());
        for (int i = 0; i < wr_q.size() && i < expw.size(); i++) begin
            chk("rq_addr", wr_q[i].addr, expw[i]);
            chk("rq_data", wr_q[i].data, 0);
            chk("rq_elig", wr_q[i].elig, 1);
        end
        chk("rq_busy_end", busy, 0);

        // init_start and a request in the same cycle: request refused, clean sweep follows
        wr_q.delete(); done_cnt = 0;
        bus.exp_valid = 1'b1;
        bus.exp_addr  = 9'd40;
        init_start    = 1'b1;
        #1;
        chk("cf_ready", bus.exp_ready, 0);
        @(negedge clk);
        bus.exp_valid = 1'b0;
        init_start    = 1'b0;
        wait_done("cf", 1000);
        check_sweep("cf");

        // Reset in the middle of a sweep
        wr_q.delete(); done_cnt = 0;
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        n = 0;
        while (!(bus.we === 1'b1 && bus.waddr === 9'd100) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rs_at100", bus.waddr, 100);
        reset = 1'b1;
        @(negedge clk);
        chk("rs_we", bus.we, 0);
        chk("rs_busy", busy, 0);
        chk("rs_done", init_done, 0);
        reset = 1'b0;
        wr_q.delete(); done_cnt = 0;
        repeat (300) @(negedge clk);
        chk("rs_nowr", wr_q.size(), 0);
        chk("rs_nodone", done_cnt, 0);
        chk("rs_busy_end", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
